// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// The state encoding is internal; only the enum names are meant to be referenced.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HALT,
    ST_ISSUE,
    ST_CAPTURE,
    ST_PRESENT,
    ST_FINISH
  } arb_state_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  // The debug path holds the memory port from the read issue until the word is handed off.
  function automatic logic debug_owns_port(arb_state_e s);
    return s inside {ST_ISSUE, ST_CAPTURE, ST_PRESENT};
  endfunction

  function automatic logic dump_in_progress(arb_state_e s);
    return s inside {ST_WAIT_HALT, ST_ISSUE, ST_CAPTURE, ST_PRESENT};
  endfunction

endpackage

// File: rtl/dump_addr_counter.sv
// Address/remaining-word bookkeeping for a debug memory dump.
// The address wraps modulo 2**ADDR_WIDTH; last flags the final word still to be handed off.
module dump_addr_counter #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   remain,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (load) begin
      addr_q   <= base;
      remain_q <= count;
    end else if (step) begin
      addr_q   <= addr_q + ADDR_WIDTH'(1);
      remain_q <= remain_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  assign addr   = addr_q;
  assign remain = remain_q;
  assign last   = (remain_q == (ADDR_WIDTH + 1)'(1));

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the data_memory port between the MEM stage and a debug dump engine.
// Pipeline traffic passes through untouched unless a dump is actively using the port.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pipe_mem_write,
  input  logic                  i_pipe_mem_read,
  input  logic [1:0]            i_pipe_mem_size,
  input  logic                  i_pipe_unsigned,
  input  logic [1:0]            i_pipe_byte_off,
  input  logic [ADDR_WIDTH-1:0] i_pipe_address,
  input  logic [DATA_WIDTH-1:0] i_pipe_wdata,
  output logic [DATA_WIDTH-1:0] o_pipe_rdata,
  output logic                  o_pipe_stall,
  input  logic                  i_pipe_halted,
  input  logic                  i_dump_start,
  input  logic [ADDR_WIDTH-1:0] i_dump_base,
  input  logic [ADDR_WIDTH:0]   i_dump_count,
  output logic                  o_dump_busy,
  output logic                  o_dump_valid,
  input  logic                  i_dump_ready,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_done,
  output logic                  o_mem_write,
  output logic                  o_mem_read,
  output logic [1:0]            o_mem_size,
  output logic                  o_mem_unsigned,
  output logic [1:0]            o_mem_byte_off,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_e            state_q, state_d;
  logic                  load, step, last;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;

  dump_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_counter (
    .clk    (i_clk),
    .rst_n  (i_reset),
    .load   (load),
    .step   (step),
    .base   (i_dump_base),
    .count  (i_dump_count),
    .addr   (addr_q),
    .remain (remain_q),
    .last   (last)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          load    = 1'b1;
          state_d = (i_dump_count == '0) ? ST_FINISH : ST_WAIT_HALT;
        end
      end
      ST_WAIT_HALT: if (i_pipe_halted) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_PRESENT;
      ST_PRESENT: begin
        if (i_dump_ready) begin
          step    = 1'b1;
          state_d = last ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  // NOTE: o_dump_data is a single architectural register, so it is cleared on reset like the flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      o_dump_busy  <= 1'b0;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      o_dump_data  <= '0;
    end else begin
      state_q      <= state_d;
      o_dump_busy  <= dump_in_progress(state_d);
      o_dump_valid <= (state_d == ST_PRESENT);
      o_dump_done  <= (state_d == ST_FINISH);
      if (state_q == ST_CAPTURE) o_dump_data <= i_mem_rdata;
    end
  end

  always_comb begin
    o_mem_write    = i_pipe_mem_write;
    o_mem_read     = i_pipe_mem_read;
    o_mem_size     = i_pipe_mem_size;
    o_mem_unsigned = i_pipe_unsigned;
    o_mem_byte_off = i_pipe_byte_off;
    o_mem_address  = i_pipe_address;
    o_mem_wdata    = i_pipe_wdata;
    o_pipe_stall   = 1'b0;
    if (debug_owns_port(state_q)) begin
      o_mem_write    = 1'b0;
      o_mem_read     = (state_q == ST_ISSUE);
      o_mem_size     = MEM_SIZE_WORD;
      o_mem_unsigned = 1'b0;
      o_mem_byte_off = 2'b00;
      o_mem_address  = addr_q;
      o_mem_wdata    = '0;
      o_pipe_stall   = i_pipe_mem_read | i_pipe_mem_write;
    end
    // Keep stray pipeline stores away from memory while reset is held.
    if (!i_reset) begin
      o_mem_write    = 1'b0;
      o_mem_read     = 1'b0;
      o_mem_size     = 2'b00;
      o_mem_unsigned = 1'b0;
      o_mem_byte_off = 2'b00;
      o_mem_address  = '0;
      o_mem_wdata    = '0;
      o_pipe_stall   = 1'b0;
    end
  end

  assign o_pipe_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: passthrough vectors, directed dump corner
// cases and randomized dumps scored against a word-level shadow of memory contents.
module tb_dmem_access_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_pipe_mem_write, i_pipe_mem_read, i_pipe_unsigned;
  logic [1:0]    i_pipe_mem_size, i_pipe_byte_off;
  logic [AW-1:0] i_pipe_address;
  logic [DW-1:0] i_pipe_wdata;
  logic [DW-1:0] o_pipe_rdata;
  logic          o_pipe_stall;
  logic          i_pipe_halted;
  logic          i_dump_start;
  logic [AW-1:0] i_dump_base;
  logic [AW:0]   i_dump_count;
  logic          o_dump_busy, o_dump_valid, i_dump_ready, o_dump_done;
  logic [DW-1:0] o_dump_data;
  logic          o_mem_write, o_mem_read, o_mem_unsigned;
  logic [1:0]    o_mem_size, o_mem_byte_off;
  logic [AW-1:0] o_mem_address;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 i_clk = ~i_clk;

  dmem_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pipe_mem_write(i_pipe_mem_write), .i_pipe_mem_read(i_pipe_mem_read),
    .i_pipe_mem_size(i_pipe_mem_size), .i_pipe_unsigned(i_pipe_unsigned),
    .i_pipe_byte_off(i_pipe_byte_off), .i_pipe_address(i_pipe_address),
    .i_pipe_wdata(i_pipe_wdata), .o_pipe_rdata(o_pipe_rdata), .o_pipe_stall(o_pipe_stall),
    .i_pipe_halted(i_pipe_halted), .i_dump_start(i_dump_start), .i_dump_base(i_dump_base),
    .i_dump_count(i_dump_count), .o_dump_busy(o_dump_busy), .o_dump_valid(o_dump_valid),
    .i_dump_ready(i_dump_ready), .o_dump_data(o_dump_data), .o_dump_done(o_dump_done),
    .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_mem_size(o_mem_size),
    .o_mem_unsigned(o_mem_unsigned), .o_mem_byte_off(o_mem_byte_off),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // data_memory stand-in: byte-lane stores, one-cycle read latency, read counter.
  logic [DW-1:0] mem [DEPTH];
  int            n_reads = 0;

  always @(posedge i_clk) begin
    if (o_mem_write) begin
      case (o_mem_size)
        2'b00:   mem[o_mem_address][8*o_mem_byte_off +: 8]     <= o_mem_wdata[7:0];
        2'b01:   mem[o_mem_address][16*o_mem_byte_off[1] +: 16] <= o_mem_wdata[15:0];
        default: mem[o_mem_address]                             <= o_mem_wdata;
      endcase
    end
    if (o_mem_read) begin
      mem_rdata <= mem[o_mem_address];
      n_reads   <= n_reads + 1;
    end
  end

  // Reference: what each word of memory should hold, tracked from the stores the bench issues.
  logic [DW-1:0] ref_mem [DEPTH];
  int            acc_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_pipe();
    i_pipe_mem_write = 1'b0;
    i_pipe_mem_read  = 1'b0;
    i_pipe_mem_size  = 2'b10;
    i_pipe_unsigned  = 1'b0;
    i_pipe_byte_off  = 2'b00;
    i_pipe_address   = '0;
    i_pipe_wdata     = '0;
  endtask

  task automatic pipe_store(input int addr, input logic [DW-1:0] data);
    i_pipe_mem_write = 1'b1;
    i_pipe_mem_size  = 2'b10;
    i_pipe_address   = AW'(addr);
    i_pipe_wdata     = data;
    step_clk();
    i_pipe_mem_write = 1'b0;
    ref_mem[addr]    = data;
  endtask

  // Runs one dump with randomized ready; optionally holds ready low for hold_len cycles on word hold_word.
  // Cycle 0 is the first sample after the edge that latched i_dump_start.
  task automatic run_dump(input int base, input int cnt, input int ready_pct, input int hold_word,
                          input int hold_len, input string tag, output int done_cyc);
    int got = 0, held = 0, cyc = 0, hold_reads = 0, reads0;
    bit done = 0;
    done_cyc = -1;
    acc_q.delete();
    reads0        = n_reads;
    i_pipe_halted = 1'b1;
    i_dump_base   = AW'(base);
    i_dump_count  = (AW + 1)'(cnt);
    i_dump_start  = 1'b1;
    step_clk();
    i_dump_start  = 1'b0;
    while (!done && cyc < 20 * cnt + 50) begin
      if (o_dump_valid && got == hold_word && held < hold_len) begin
        i_dump_ready = 1'b0;
        if (held == 0) hold_reads = n_reads;
        else check({tag, "_hold_noread"}, 64'(n_reads), 64'(hold_reads));
        held++;
      end else begin
        i_dump_ready = ($urandom_range(0, 99) < ready_pct);
      end
      #1;
      if (o_dump_done) begin
        done     = 1;
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, 64'(o_dump_busy), 64'd0);
      end else if (o_dump_valid) begin
        check({tag, "_word"}, 64'(o_dump_data), 64'(ref_mem[(base + got) % DEPTH]));
        if (i_dump_ready) begin
          acc_q.push_back(cyc);
          got++;
        end
      end
      step_clk();
      cyc++;
    end
    i_dump_ready = 1'b0;
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    check({tag, "_words"}, 64'(got), 64'(cnt));
    check({tag, "_reads"}, 64'(n_reads - reads0), 64'(cnt));
    check({tag, "_done_pulse"}, 64'(o_dump_done), 64'd0);
  endtask

  typedef struct {
    logic          wr, rd;
    logic [1:0]    size;
    logic          uns;
    logic [1:0]    off;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [47:0]   exp_bus;
    logic          exp_stall;
  } pt_vec_t;

  initial begin
    pt_vec_t vecs[6];
    int      dc, base, cnt, seen;
    logic [DW-1:0] w;

    // Passthrough vectors: in IDLE the memory bus must mirror the pipeline request exactly.
    vecs[0] = '{1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 9'd17,  32'h0,        {1'b0,1'b1,2'b10,1'b0,2'b00,9'd17, 32'h0       }, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b11, 9'd511, 32'h000000A5, {1'b1,1'b0,2'b00,1'b0,2'b11,9'd511,32'h000000A5}, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 1'b1, 2'b10, 9'd256, 32'h0,        {1'b0,1'b1,2'b01,1'b1,2'b10,9'd256,32'h0       }, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 9'd0,   32'hCAFEF00D, {1'b1,1'b0,2'b10,1'b0,2'b00,9'd0,  32'hCAFEF00D}, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 9'd300, 32'h12345678, {1'b0,1'b0,2'b00,1'b1,2'b01,9'd300,32'h12345678}, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 9'd85,  32'h0,        {1'b0,1'b1,2'b00,1'b1,2'b01,9'd85, 32'h0       }, 1'b0};

    clear_pipe();
    i_pipe_halted = 1'b0;
    i_dump_start  = 1'b0;
    i_dump_base   = '0;
    i_dump_count  = '0;
    i_dump_ready  = 1'b0;

    // Reset with a store request pending: nothing may reach memory and all outputs are 0.
    i_reset          = 1'b0;
    i_pipe_mem_write = 1'b1;
    i_pipe_mem_read  = 1'b1;
    i_pipe_wdata     = 32'hFFFF_FFFF;
    repeat (3) step_clk();
    check("rst_mem_write", 64'(o_mem_write), 64'd0);
    check("rst_mem_read", 64'(o_mem_read), 64'd0);
    check("rst_stall", 64'(o_pipe_stall), 64'd0);
    check("rst_flags", 64'({o_dump_busy, o_dump_valid, o_dump_done}), 64'd0);
    check("rst_dump_data", 64'(o_dump_data), 64'd0);
    clear_pipe();
    i_reset = 1'b1;
    step_clk();

    foreach (vecs[i]) begin
      i_pipe_mem_write = vecs[i].wr;
      i_pipe_mem_read  = vecs[i].rd;
      i_pipe_mem_size  = vecs[i].size;
      i_pipe_unsigned  = vecs[i].uns;
      i_pipe_byte_off  = vecs[i].off;
      i_pipe_address   = vecs[i].addr;
      i_pipe_wdata     = vecs[i].wdata;
      #1;
      check($sformatf("pt_bus_%0d", i), 64'({o_mem_write, o_mem_read, o_mem_size, o_mem_unsigned,
            o_mem_byte_off, o_mem_address, o_mem_wdata}), 64'(vecs[i].exp_bus));
      check($sformatf("pt_stall_%0d", i), 64'(o_pipe_stall), 64'(vecs[i].exp_stall));
      step_clk();
    end
    clear_pipe();

    // Fill all of memory through the pipeline path.
    for (int a = 0; a < DEPTH; a++) pipe_store(a, $urandom());

    // Word store then load at address 17.
    pipe_store(17, 32'hDEADBEEF);
    i_pipe_mem_read = 1'b1;
    i_pipe_address  = 9'd17;
    #1;
    check("pt_load_stall", 64'(o_pipe_stall), 64'd0);
    step_clk();
    check("pt_load_rdata", 64'(o_pipe_rdata), 64'hDEADBEEF);
    clear_pipe();

    // Basic dump: 2 cycles to reach ISSUE, then 3 cycles per word with ready held high.
    for (int k = 0; k < 4; k++) pipe_store(10 + k, DW'(k + 1));
    run_dump(10, 4, 100, -1, 0, "basic", dc);
    check("basic_done_cyc", 64'(dc), 64'd13);
    check("basic_acc_n", 64'(acc_q.size()), 64'd4);
    for (int k = 0; k < acc_q.size(); k++)
      check($sformatf("basic_acc_cyc_%0d", k), 64'(acc_q[k]), 64'(3 + 3 * k));

    // Backpressure on the second word delays completion by exactly the hold length.
    run_dump(10, 4, 100, 1, 5, "bp", dc);
    check("bp_done_cyc", 64'(dc), 64'd18);

    // Address wrap and the empty dump.
    run_dump(510, 3, 100, -1, 0, "wrap", dc);
    run_dump(123, 0, 100, -1, 0, "zero", dc);
    check("zero_done_cyc", 64'(dc), 64'd0);

    // Halt gating, then pipeline requests while the dump owns the port.
    i_pipe_halted = 1'b0;
    i_dump_base   = 9'd100;
    i_dump_count  = 10'd1;
    i_dump_start  = 1'b1;
    step_clk();
    i_dump_start = 1'b0;
    base = n_reads;
    repeat (5) step_clk();
    check("halt_busy", 64'(o_dump_busy), 64'd1);
    check("halt_no_read", 64'(n_reads), 64'(base));
    i_pipe_halted = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (o_dump_valid) seen = 1;
      else step_clk();
    end
    check("halt_valid_seen", 64'(seen), 64'd1);
    i_pipe_halted   = 1'b0;
    i_pipe_mem_read = 1'b1;
    i_pipe_address  = 9'd5;
    #1;
    check("own_load_stall", 64'(o_pipe_stall), 64'd1);
    check("own_load_blocked", 64'(o_mem_read), 64'd0);
    i_pipe_mem_read  = 1'b0;
    i_pipe_mem_write = 1'b1;
    #1;
    check("own_store_stall", 64'(o_pipe_stall), 64'd1);
    check("own_store_blocked", 64'(o_mem_write), 64'd0);
    check("own_data", 64'(o_dump_data), 64'(ref_mem[100]));
    clear_pipe();
    i_dump_ready = 1'b1;
    step_clk();
    i_dump_ready = 1'b0;
    check("halt_done", 64'(o_dump_done), 64'd1);
    step_clk();
    check("halt_idle_busy", 64'(o_dump_busy), 64'd0);
    i_pipe_mem_read = 1'b1;
    #1;
    check("idle_no_stall", 64'(o_pipe_stall), 64'd0);
    clear_pipe();

    // Reset while a word is being presented: abort with no done pulse.
    i_pipe_halted = 1'b1;
    i_dump_base   = 9'd10;
    i_dump_count  = 10'd4;
    i_dump_start  = 1'b1;
    step_clk();
    i_dump_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (o_dump_valid) seen = 1;
      else step_clk();
    end
    check("rstmid_valid_seen", 64'(seen), 64'd1);
    i_reset = 1'b0;
    step_clk();
    i_reset = 1'b1;
    check("rstmid_flags", 64'({o_dump_busy, o_dump_valid, o_dump_done}), 64'd0);
    seen = 0;
    repeat (6) begin
      step_clk();
      if (o_dump_done || o_dump_busy) seen = 1;
    end
    check("rstmid_quiet", 64'(seen), 64'd0);

    // Randomized dumps interleaved with pipeline stores.
    for (int it = 0; it < 15; it++) begin
      repeat ($urandom_range(1, 4)) begin
        w = $urandom();
        pipe_store($urandom_range(0, DEPTH - 1), w);
      end
      base = $urandom_range(0, DEPTH - 1);
      cnt  = $urandom_range(0, 40);
      run_dump(base, cnt, $urandom_range(30, 100), -1, 0, $sformatf("rnd%0d", it), dc);
    end

    // Full-depth dump reads every word exactly once.
    run_dump($urandom_range(0, DEPTH - 1), DEPTH, 100, -1, 0, "full", dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
